// File: rtl/lc3_mem_model.sv
// Cycle-accurate instruction/data memory responder for the LC3 pipeline bench.
// One shared array, two independent fixed-latency channels, backdoor preload port.
module lc3_mem_model #(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DEPTH     = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h3000,
  parameter int unsigned       INSTR_LAT = 1,
  parameter int unsigned       DATA_LAT  = 2,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instrmem_rd,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              data_req,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  input  logic              stall,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              err_instr,
  output logic              err_data,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic [CNT_W-1:0]  data_rd_cnt,
  output logic [CNT_W-1:0]  data_wr_cnt
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, BUSY} chan_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  // Range test is done on the full-width offset so a wrapped subtraction never aliases a hit.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ({1'b0, off} < (ADDR_W+1)'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return off[IDX_W-1:0];
  endfunction

  chan_state_t       i_state;
  logic [3:0]        i_cnt;
  logic [ADDR_W-1:0] i_addr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_state        <= IDLE;
      i_cnt          <= '0;
      i_addr         <= '0;
      Instr_dout     <= '0;
      complete_instr <= 1'b0;
      err_instr      <= 1'b0;
      instr_cnt      <= '0;
    end else begin
      complete_instr <= 1'b0;
      case (i_state)
        IDLE: if (instrmem_rd) begin
          i_state <= BUSY;
          i_addr  <= pc;
          i_cnt   <= 4'(INSTR_LAT - 1);
        end
        BUSY: if (!stall) begin
          if (i_cnt != '0) begin
            i_cnt <= i_cnt - 4'd1;
          end else begin
            complete_instr <= 1'b1;
            Instr_dout     <= in_range(i_addr) ? mem[to_idx(i_addr)] : '0;
            if (!in_range(i_addr)) err_instr <= 1'b1;
            instr_cnt      <= instr_cnt + CNT_W'(1);
            i_state        <= IDLE;
          end
        end
        default: i_state <= IDLE;
      endcase
    end
  end

  chan_state_t       d_state;
  logic [3:0]        d_cnt;
  logic [ADDR_W-1:0] d_addr;
  logic              d_rd;
  logic [DATA_W-1:0] d_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_state       <= IDLE;
      d_cnt         <= '0;
      d_addr        <= '0;
      d_rd          <= 1'b0;
      d_wdata       <= '0;
      Data_dout     <= '0;
      complete_data <= 1'b0;
      err_data      <= 1'b0;
      data_rd_cnt   <= '0;
      data_wr_cnt   <= '0;
    end else begin
      complete_data <= 1'b0;
      case (d_state)
        IDLE: if (data_req) begin
          d_state <= BUSY;
          d_addr  <= Data_addr;
          d_rd    <= Data_rd;
          d_wdata <= Data_din;
          d_cnt   <= 4'(DATA_LAT - 1);
        end
        BUSY: if (!stall) begin
          if (d_cnt != '0) begin
            d_cnt <= d_cnt - 4'd1;
          end else begin
            complete_data <= 1'b1;
            if (d_rd) begin
              Data_dout   <= in_range(d_addr) ? mem[to_idx(d_addr)] : '0;
              data_rd_cnt <= data_rd_cnt + CNT_W'(1);
            end else begin
              data_wr_cnt <= data_wr_cnt + CNT_W'(1);
            end
            if (!in_range(d_addr)) err_data <= 1'b1;
            d_state <= IDLE;
          end
        end
        default: d_state <= IDLE;
      endcase
    end
  end

  logic d_commit;

  always_comb begin
    d_commit = (d_state == BUSY) && !stall && (d_cnt == '0) && !d_rd && in_range(d_addr);
  end

  // Array has no reset so preload survives; the later backdoor assignment wins a same-index collision.
  always_ff @(posedge clock) begin
    if (d_commit) mem[to_idx(d_addr)] <= d_wdata;
    if (load_en && in_range(load_addr)) mem[to_idx(load_addr)] <= load_data;
  end

endmodule

// File: tb/tb_lc3_mem_model.sv
// Self-checking bench for lc3_mem_model: directed table, hand sequences for
// collisions/reset, and randomized traffic against an array-based reference.
module tb_lc3_mem_model;
  localparam int DEPTH = 1024;
  localparam int IL    = 1;
  localparam int DL    = 2;

  logic        clock = 1'b0;
  logic        reset, instrmem_rd, data_req, Data_rd, stall, load_en;
  logic [15:0] pc, Instr_dout, Data_addr, Data_din, Data_dout, load_addr, load_data;
  logic        complete_instr, complete_data, err_instr, err_data;
  logic [31:0] instr_cnt, data_rd_cnt, data_wr_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] model [DEPTH];
  int          e_ic, e_rc, e_wc;
  logic        e_ei, e_ed;
  logic [15:0] e_ddout;

  typedef struct {
    bit          is_i;
    logic        rd;
    logic [15:0] a;
    logic [15:0] wd;
    int          nst;
    logic [15:0] exp_dout;
    int          exp_lat;
  } vec_t;
  vec_t vt [7];

  lc3_mem_model #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .BASE_ADDR(16'h3000),
                  .INSTR_LAT(IL), .DATA_LAT(DL), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .instrmem_rd(instrmem_rd), .pc(pc),
    .Instr_dout(Instr_dout), .complete_instr(complete_instr),
    .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .Data_dout(Data_dout), .complete_data(complete_data), .stall(stall),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .err_instr(err_instr), .err_data(err_data), .instr_cnt(instr_cnt),
    .data_rd_cnt(data_rd_cnt), .data_wr_cnt(data_wr_cnt));

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit hit(input logic [15:0] a);
    return (a >= 16'h3000) && ((int'(a) - 'h3000) < DEPTH);
  endfunction

  function automatic int idx(input logic [15:0] a);
    return int'(a) - 'h3000;
  endfunction

  // One request, then wait (bounded) for completion; stall held for the first nst edges after acceptance.
  task automatic op(input bit is_i, input logic rd, input logic [15:0] a, input logic [15:0] wd,
                    input int nst, output int lat, output logic [15:0] dout, output bit pw_ok);
    int waited;
    bit seen;
    if (is_i) begin
      instrmem_rd = 1'b1; pc = a;
    end else begin
      data_req = 1'b1; Data_rd = rd; Data_addr = a; Data_din = wd;
    end
    @(posedge clock); #1;
    instrmem_rd = 1'b0; data_req = 1'b0; stall = (nst > 0);
    seen = 1'b0; waited = 0;
    while (!seen && waited < 40) begin
      @(posedge clock); #1;
      waited++;
      if (waited >= nst) stall = 1'b0;
      if (is_i ? complete_instr : complete_data) seen = 1'b1;
    end
    stall = 1'b0;
    lat   = seen ? waited : -1;
    dout  = is_i ? Instr_dout : Data_dout;
    @(posedge clock); #1;
    pw_ok = is_i ? !complete_instr : !complete_data;
  endtask

  task automatic run_op(input string tag, input bit is_i, input logic rd, input logic [15:0] a,
                        input logic [15:0] wd, input int nst, output int lat, output logic [15:0] dout);
    logic [15:0] exp;
    bit pw;
    op(is_i, rd, a, wd, nst, lat, dout, pw);
    if (is_i) begin
      exp = hit(a) ? model[idx(a)] : 16'h0000;
      e_ic++;
      e_ei |= !hit(a);
    end else if (rd) begin
      exp = hit(a) ? model[idx(a)] : 16'h0000;
      e_ddout = exp;
      e_rc++;
      e_ed |= !hit(a);
    end else begin
      exp = e_ddout;
      if (hit(a)) model[idx(a)] = wd;
      e_wc++;
      e_ed |= !hit(a);
    end
    check({tag, " latency"}, lat, (is_i ? IL : DL) + nst);
    check({tag, " dout"}, dout, exp);
    check({tag, " pulse width"}, 32'(pw), 32'd1);
    check({tag, " err_instr"}, 32'(err_instr), 32'(e_ei));
    check({tag, " err_data"}, 32'(err_data), 32'(e_ed));
    check({tag, " instr_cnt"}, instr_cnt, e_ic);
    check({tag, " data_rd_cnt"}, data_rd_cnt, e_rc);
    check({tag, " data_wr_cnt"}, data_wr_cnt, e_wc);
  endtask

  initial begin
    int          lat;
    logic [15:0] dout, old, a;
    bit          seen;

    reset = 1'b1; instrmem_rd = 1'b0; data_req = 1'b0; Data_rd = 1'b0; stall = 1'b0;
    load_en = 1'b0; pc = '0; Data_addr = '0; Data_din = '0; load_addr = '0; load_data = '0;
    e_ic = 0; e_rc = 0; e_wc = 0; e_ei = 1'b0; e_ed = 1'b0; e_ddout = '0;
    #1;
    check("reset complete_instr", 32'(complete_instr), 0);
    check("reset complete_data", 32'(complete_data), 0);
    check("reset Instr_dout", 32'(Instr_dout), 0);
    check("reset Data_dout", 32'(Data_dout), 0);
    check("reset errs", 32'({err_instr, err_data}), 0);
    check("reset counters", instr_cnt | data_rd_cnt | data_wr_cnt, 0);

    // Preload the whole array through the backdoor while reset is still high.
    for (int i = 0; i < DEPTH; i++) begin
      model[i]  = (i == 0) ? 16'h1261 : (i == 1) ? 16'h5020 : 16'($urandom);
      load_en   = 1'b1;
      load_addr = 16'h3000 + 16'(i);
      load_data = model[i];
      @(posedge clock); #1;
    end
    load_en = 1'b0;
    reset   = 1'b0;

    vt[0] = '{1'b1, 1'b1, 16'h3000, 16'h0000, 0, 16'h1261, 1};
    vt[1] = '{1'b1, 1'b1, 16'h3001, 16'h0000, 0, 16'h5020, 1};
    vt[2] = '{1'b0, 1'b0, 16'h3010, 16'hBEEF, 0, 16'h0000, 2};
    vt[3] = '{1'b0, 1'b1, 16'h3010, 16'h0000, 0, 16'hBEEF, 2};
    vt[4] = '{1'b1, 1'b1, 16'h3010, 16'h0000, 4, 16'hBEEF, 5};
    vt[5] = '{1'b0, 1'b0, 16'h3005, 16'h1234, 1, 16'hBEEF, 3};
    vt[6] = '{1'b0, 1'b1, 16'h3005, 16'h0000, 0, 16'h1234, 2};
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vt[i].is_i, vt[i].rd, vt[i].a, vt[i].wd, vt[i].nst, lat, dout);
      check($sformatf("vec%0d table dout", i), 32'(dout), 32'(vt[i].exp_dout));
      check($sformatf("vec%0d table latency", i), lat, vt[i].exp_lat);
    end

    // data_req held high: accept at edge 1, complete at 3, re-accept at 4, and so on.
    data_req = 1'b1; Data_rd = 1'b1; Data_addr = 16'h3010;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clock); #1;
      check($sformatf("b2b edge%0d complete_data", k), 32'(complete_data), 32'((k % 3) == 0));
    end
    data_req = 1'b0;
    e_rc += 3;
    e_ddout = 16'hBEEF;
    check("b2b Data_dout", 32'(Data_dout), 32'h0000BEEF);
    check("b2b data_rd_cnt", data_rd_cnt, e_rc);
    @(posedge clock); #1;

    run_op("oor instr 2FFF", 1'b1, 1'b1, 16'h2FFF, 16'h0, 0, lat, dout);
    run_op("oor data rd 2FFF", 1'b0, 1'b1, 16'h2FFF, 16'h0, 0, lat, dout);
    run_op("oor data wr top", 1'b0, 1'b0, 16'h3000 + 16'(DEPTH), 16'hDEAD, 0, lat, dout);
    run_op("base after oor wr", 1'b1, 1'b1, 16'h3000, 16'h0, 0, lat, dout);
    run_op("last valid word", 1'b0, 1'b1, 16'h3000 + 16'(DEPTH - 1), 16'h0, 0, lat, dout);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(7) == 0)
        a = $urandom_range(1) ? 16'h2FFF - 16'($urandom_range(255))
                              : 16'h3000 + 16'(DEPTH) + 16'($urandom_range(255));
      else
        a = 16'h3000 + 16'($urandom_range(DEPTH - 1));
      run_op($sformatf("rand%0d", n), 1'($urandom_range(1)), 1'($urandom_range(1)), a,
             16'($urandom), $urandom_range(3), lat, dout);
    end

    // Same-edge collisions: instr read sees the old word, backdoor beats the data write.
    old = model[idx(16'h3030)];
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3030; Data_din = 16'h1111;
    @(posedge clock); #1;
    data_req = 1'b0; instrmem_rd = 1'b1; pc = 16'h3030;
    @(posedge clock); #1;
    instrmem_rd = 1'b0; load_en = 1'b1; load_addr = 16'h3030; load_data = 16'h2222;
    @(posedge clock); #1;
    load_en = 1'b0;
    check("collide complete_data", 32'(complete_data), 1);
    check("collide complete_instr", 32'(complete_instr), 1);
    check("collide read-before-write", 32'(Instr_dout), 32'(old));
    model[idx(16'h3030)] = 16'h2222;
    e_ic++; e_wc++;
    @(posedge clock); #1;
    run_op("backdoor wins", 1'b1, 1'b1, 16'h3030, 16'h0, 0, lat, dout);

    // Reset one cycle after a write is accepted: cleared asynchronously, write never lands.
    old = model[idx(16'h3020)];
    data_req = 1'b1; Data_rd = 1'b0; Data_addr = 16'h3020; Data_din = ~old;
    @(posedge clock); #1;
    data_req = 1'b0;
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check("async rst counters", instr_cnt | data_rd_cnt | data_wr_cnt, 0);
    check("async rst errs", 32'({err_instr, err_data}), 0);
    check("async rst douts", 32'(Instr_dout | Data_dout), 0);
    e_ic = 0; e_rc = 0; e_wc = 0; e_ei = 1'b0; e_ed = 1'b0; e_ddout = '0;
    seen = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
      if (complete_data) seen = 1'b1;
    end
    check("rst cancels completion", 32'(seen), 0);
    reset = 1'b0;
    run_op("word after cancelled wr", 1'b0, 1'b1, 16'h3020, 16'h0, 0, lat, dout);
    run_op("preload after reset", 1'b1, 1'b1, 16'h3001, 16'h0, 0, lat, dout);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
